// File: rtl/fc_ctrl_pkg.sv
// Shared state encoding and width helper for the fully-connected layer sequencer.
package fc_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PEND,
    LOAD,
    START,
    WAIT,
    ACC,
    DONE
  } t_fc_ctrl_state;

  function automatic int clog2_min1(input int value);
    return (value <= 1) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/cim_start_tracker.sv
// Per-tile start handshake: holds start on each tile until it has been seen busy.
// Combinational start/flag outputs; a tile that never drops ready keeps its start high.
module cim_start_tracker
  import fc_ctrl_pkg::*;
#(
  parameter int NUM_TILES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 enable,
  input  logic [NUM_TILES-1:0] i_cim_ready,
  output logic [NUM_TILES-1:0] o_cim_start,
  output logic                 all_started,
  output logic                 all_ready
);

  logic [NUM_TILES-1:0] started_q;
  logic [NUM_TILES-1:0] started_d;

  // A tile counts as started in the very cycle it drops ready.
  always_comb begin
    started_d = started_q;
    if (clear) begin
      started_d = '0;
    end else if (enable) begin
      started_d = started_q | ~i_cim_ready;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      started_q <= '0;
    end else begin
      started_q <= started_d;
    end
  end

  assign o_cim_start = enable ? ~started_q : '0;
  assign all_started = &started_q;
  assign all_ready   = &i_cim_ready;

endmodule

// File: rtl/fc_layer_ctrl.sv
// Bit-serial sequencer for one FC layer over NUM_TILES stacked CIM tiles sharing an input bus.
// Per bit: NUM_TILES*NUM_ADDR load cycles, start handshake, CIM busy wait, one accumulate cycle.
module fc_layer_ctrl
  import fc_ctrl_pkg::*;
#(
  parameter int DATA_SIZE   = 8,
  parameter int NUM_TILES   = 4,
  parameter int NUM_ADDR    = 8,
  parameter int INPUT_COUNT = 4,
  parameter int COUNT_WIDTH = clog2_min1(DATA_SIZE),
  parameter int ADDR_WIDTH  = clog2_min1(NUM_ADDR)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_start,
  output logic                   o_ready,
  output logic [COUNT_WIDTH-1:0] o_count,
  output logic [ADDR_WIDTH-1:0]  o_addr,
  output logic [NUM_TILES-1:0]   o_tile_sel,
  output logic                   o_cim_we,
  input  logic [NUM_TILES-1:0]   i_cim_ready,
  output logic [NUM_TILES-1:0]   o_cim_start,
  output logic                   o_acc_clr,
  output logic                   o_acc_en,
  input  logic                   i_func_ready,
  output logic                   o_func_start
);

  localparam int IN_W   = clog2_min1(INPUT_COUNT);
  localparam int TILE_W = clog2_min1(NUM_TILES);

  localparam logic [IN_W-1:0]        IN_LAST    = IN_W'(INPUT_COUNT - 1);
  localparam logic [COUNT_WIDTH-1:0] COUNT_LAST = COUNT_WIDTH'(DATA_SIZE - 1);
  localparam logic [ADDR_WIDTH-1:0]  ADDR_LAST  = ADDR_WIDTH'(NUM_ADDR - 1);
  localparam logic [TILE_W-1:0]      TILE_LAST  = TILE_W'(NUM_TILES - 1);

  t_fc_ctrl_state         state_q, state_d;
  logic [IN_W-1:0]        in_cnt_q, in_cnt_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [TILE_W-1:0]      tile_q, tile_d;

  logic tracker_clear;
  logic tracker_enable;
  logic all_started;
  logic all_ready;

  assign tracker_enable = (state_q == START);

  cim_start_tracker #(
    .NUM_TILES (NUM_TILES)
  ) u_start_tracker (
    .clk         (clk),
    .rst         (rst),
    .clear       (tracker_clear),
    .enable      (tracker_enable),
    .i_cim_ready (i_cim_ready),
    .o_cim_start (o_cim_start),
    .all_started (all_started),
    .all_ready   (all_ready)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      in_cnt_q <= '0;
      count_q  <= '0;
      addr_q   <= '0;
      tile_q   <= '0;
    end else begin
      state_q  <= state_d;
      in_cnt_q <= in_cnt_d;
      count_q  <= count_d;
      addr_q   <= addr_d;
      tile_q   <= tile_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    in_cnt_d      = in_cnt_q;
    count_d       = count_q;
    addr_d        = addr_q;
    tile_d        = tile_q;
    tracker_clear = 1'b0;
    o_ready       = 1'b0;
    o_addr        = '0;
    o_tile_sel    = '0;
    o_cim_we      = 1'b0;
    o_acc_clr     = 1'b0;
    o_acc_en      = 1'b0;
    o_func_start  = 1'b0;

    case (state_q)
      IDLE: begin
        o_ready = 1'b1;
        if (i_start) begin
          if (in_cnt_q == IN_LAST) begin
            in_cnt_d = '0;
            count_d  = '0;
            addr_d   = '0;
            tile_d   = '0;
            state_d  = all_ready ? LOAD : PEND;
          end else begin
            in_cnt_d = in_cnt_q + 1'b1;
          end
        end
      end

      PEND: begin
        if (all_ready) begin
          state_d = LOAD;
        end
      end

      LOAD: begin
        o_cim_we   = 1'b1;
        o_addr     = addr_q;
        o_tile_sel = NUM_TILES'(1) << tile_q;
        // Every LOAD pass starts at tile 0 / addr 0, so this marks the layer's first write.
        o_acc_clr  = (count_q == '0) && (addr_q == '0) && (tile_q == '0);
        if (addr_q == ADDR_LAST) begin
          addr_d = '0;
          if (tile_q == TILE_LAST) begin
            tile_d        = '0;
            tracker_clear = 1'b1;
            state_d       = START;
          end else begin
            tile_d = tile_q + 1'b1;
          end
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end

      START: begin
        if (all_started) begin
          state_d = WAIT;
        end
      end

      WAIT: begin
        if (all_ready) begin
          state_d = ACC;
        end
      end

      ACC: begin
        o_acc_en = 1'b1;
        if (count_q == COUNT_LAST) begin
          state_d = DONE;
        end else begin
          count_d = count_q + 1'b1;
          addr_d  = '0;
          tile_d  = '0;
          state_d = LOAD;
        end
      end

      DONE: begin
        if (i_func_ready) begin
          o_func_start = 1'b1;
          count_d      = '0;
          state_d      = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign o_count = count_q;

endmodule

// File: tb/tb_fc_layer_ctrl.sv
// Directed bench for fc_layer_ctrl: vector table for reset/load, hand sequences for handshakes.
module tb_fc_layer_ctrl;

  localparam int DS = 8;
  localparam int NT = 4;
  localparam int NA = 8;
  localparam int IC = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_start = 1'b0;
  logic [NT-1:0] i_cim_ready = '1;
  logic          i_func_ready = 1'b1;
  logic          o_ready;
  logic [2:0]    o_count;
  logic [2:0]    o_addr;
  logic [NT-1:0] o_tile_sel;
  logic          o_cim_we;
  logic [NT-1:0] o_cim_start;
  logic          o_acc_clr;
  logic          o_acc_en;
  logic          o_func_start;

  fc_layer_ctrl #(
    .DATA_SIZE   (DS),
    .NUM_TILES   (NT),
    .NUM_ADDR    (NA),
    .INPUT_COUNT (IC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_start      (i_start),
    .o_ready      (o_ready),
    .o_count      (o_count),
    .o_addr       (o_addr),
    .o_tile_sel   (o_tile_sel),
    .o_cim_we     (o_cim_we),
    .i_cim_ready  (i_cim_ready),
    .o_cim_start  (o_cim_start),
    .o_acc_clr    (o_acc_clr),
    .o_acc_en     (o_acc_en),
    .i_func_ready (i_func_ready),
    .o_func_start (o_func_start)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   busy[NT];
  logic auto_cim = 1'b0;

  // {ready, count, addr, tile_sel, we, cim_start, acc_clr, acc_en, func_start}
  logic [18:0] outs;
  assign outs = {o_ready, o_count, o_addr, o_tile_sel, o_cim_we, o_cim_start,
                 o_acc_clr, o_acc_en, o_func_start};

  function automatic logic [18:0] pk(input logic rdy, input logic [2:0] cnt, input logic [2:0] adr,
                                     input logic [3:0] ts, input logic we, input logic [3:0] cs,
                                     input logic clr, input logic en, input logic fs);
    return {rdy, cnt, adr, ts, we, cs, clr, en, fs};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one cycle; tiles in auto mode go busy for 5 cycles when started.
  task automatic cyc();
    logic [NT-1:0] s;
    s = o_cim_start;
    @(posedge clk);
    #1;
    if (auto_cim) begin
      for (int t = 0; t < NT; t++) begin
        if (busy[t] > 0) busy[t]--;
        if (s[t] && busy[t] == 0) busy[t] = 5;
        i_cim_ready[t] = (busy[t] == 0);
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    i_start = 1'b0;
    i_func_ready = 1'b1;
    auto_cim = 1'b0;
    i_cim_ready = '1;
    for (int t = 0; t < NT; t++) busy[t] = 0;
    @(negedge clk);
    chk("reset_outs", 32'(outs), 32'(pk(1'b1, 3'd0, 3'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0)));
    cyc();
    rst = 1'b1;
  endtask

  task automatic pulse_starts(input int n, input logic [3:0] rdy);
    for (int i = 0; i < n; i++) begin
      i_start = 1'b1;
      i_cim_ready = rdy;
      @(negedge clk);
      cyc();
    end
    i_start = 1'b0;
  endtask

  task automatic run_layer(input int hold, input string tag);
    int   n_acc, n_we, n_clr, dc, fs_dc;
    logic fin;
    n_acc = 0; n_we = 0; n_clr = 0; dc = 0; fs_dc = -1; fin = 1'b0;
    auto_cim = 1'b1;
    i_func_ready = (hold == 0);
    pulse_starts(IC, 4'hF);
    for (int c = 0; c < 4000 && !fin; c++) begin
      if (n_acc == DS) dc++;
      i_func_ready = (hold == 0) || (dc > hold);
      @(negedge clk);
      if (o_acc_en) begin
        chk($sformatf("%s_acc_count%0d", tag, n_acc), 32'(o_count), 32'(n_acc));
        n_acc++;
      end
      if (o_cim_we) n_we++;
      if (o_acc_clr) n_clr++;
      if (o_func_start) begin
        fin = 1'b1;
        fs_dc = dc;
      end
      cyc();
    end
    chk($sformatf("%s_finished", tag), 32'(fin), 32'd1);
    chk($sformatf("%s_acc_pulses", tag), 32'(n_acc), 32'(DS));
    chk($sformatf("%s_we_cycles", tag), 32'(n_we), 32'(DS * NT * NA));
    chk($sformatf("%s_clr_pulses", tag), 32'(n_clr), 32'd1);
    chk($sformatf("%s_func_start_cycle", tag), 32'(fs_dc), 32'(hold + 1));
    @(negedge clk);
    chk($sformatf("%s_idle_after", tag), 32'(outs),
        32'(pk(1'b1, 3'd0, 3'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0)));
    cyc();
    auto_cim = 1'b0;
  endtask

  typedef struct {
    logic        rst_n;
    logic        start;
    logic [3:0]  rdy;
    logic [18:0] exp;
  } vec_t;

  vec_t tbl[40];

  initial begin
    logic [18:0] idle_o;
    logic [3:0]  stag_rdy[5];
    logic [3:0]  stag_cs[5];
    int          n3, n0;
    logic        found;

    idle_o = pk(1'b1, 3'd0, 3'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    tbl[0] = '{1'b0, 1'b0, 4'hF, idle_o};
    tbl[1] = '{1'b0, 1'b1, 4'hF, idle_o};
    for (int i = 2; i < 6; i++) tbl[i] = '{1'b1, 1'b1, 4'hF, idle_o};
    for (int k = 0; k < 32; k++) begin
      tbl[6 + k] = '{1'b1, (k == 3 || k == 20), 4'hF,
                     pk(1'b0, 3'd0, 3'(k % 8), 4'(1 << (k / 8)), 1'b1, 4'd0, (k == 0), 1'b0, 1'b0)};
    end
    tbl[38] = '{1'b1, 1'b0, 4'hF, pk(1'b0, 3'd0, 3'd0, 4'd0, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0)};
    tbl[39] = tbl[38];

    // Reset, input collection, one full LOAD pass, then START with tiles that never go busy.
    for (int i = 0; i < 40; i++) begin
      rst = tbl[i].rst_n;
      i_start = tbl[i].start;
      i_cim_ready = tbl[i].rdy;
      @(negedge clk);
      chk($sformatf("vec%0d", i), 32'(outs), 32'(tbl[i].exp));
      cyc();
    end
    i_start = 1'b0;

    do_reset();
    run_layer(0, "full");

    do_reset();
    run_layer(10, "hold");

    // Staggered busy: tile t drops ready t cycles into START.
    stag_rdy = '{4'hE, 4'hC, 4'h8, 4'h0, 4'h0};
    stag_cs  = '{4'hF, 4'hE, 4'hC, 4'h8, 4'h0};
    do_reset();
    pulse_starts(IC, 4'hF);
    repeat (NT * NA) begin
      @(negedge clk);
      cyc();
    end
    n3 = 0; n0 = 0;
    for (int j = 0; j < 5; j++) begin
      i_cim_ready = stag_rdy[j];
      @(negedge clk);
      chk($sformatf("stag_start%0d", j), 32'(o_cim_start), 32'(stag_cs[j]));
      if (o_cim_start[3]) n3++;
      if (o_cim_start[0]) n0++;
      cyc();
    end
    chk("stag_tile3_cycles", 32'(n3), 32'd4);
    chk("stag_tile0_cycles", 32'(n0), 32'd1);
    @(negedge clk);
    chk("stag_wait_busy", 32'(outs), 32'd0);
    cyc();
    i_cim_ready = 4'hF;
    @(negedge clk);
    chk("stag_wait_ready", 32'(outs), 32'd0);
    cyc();
    @(negedge clk);
    chk("stag_acc", 32'(outs), 32'(pk(1'b0, 3'd0, 3'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0)));
    cyc();

    // Fourth start while one tile is still busy parks in PEND.
    do_reset();
    pulse_starts(IC - 1, 4'hF);
    pulse_starts(1, 4'b1011);
    i_start = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk($sformatf("pend%0d", j), 32'(outs), 32'd0);
      cyc();
    end
    i_start = 1'b0;
    i_cim_ready = 4'hF;
    @(negedge clk);
    chk("pend_ready_back", 32'(outs), 32'd0);
    cyc();
    @(negedge clk);
    chk("pend_load", 32'(outs), 32'(pk(1'b0, 3'd0, 3'd0, 4'd1, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0)));
    cyc();

    // Reset in the middle of bit 3's LOAD.
    do_reset();
    auto_cim = 1'b1;
    pulse_starts(IC, 4'hF);
    found = 1'b0;
    for (int c = 0; c < 3000 && !found; c++) begin
      @(negedge clk);
      if (o_cim_we && o_count == 3'd3) found = 1'b1;
      else cyc();
    end
    chk("mid_found_bit3", 32'(found), 32'd1);
    #1 rst = 1'b0;
    #1 chk("mid_reset_outs", 32'(outs), 32'(idle_o));
    auto_cim = 1'b0;
    for (int t = 0; t < NT; t++) busy[t] = 0;
    i_cim_ready = 4'hF;
    cyc();
    rst = 1'b1;
    pulse_starts(IC - 1, 4'hF);
    @(negedge clk);
    chk("mid_three_starts_idle", 32'(outs), 32'(idle_o));
    cyc();
    pulse_starts(1, 4'hF);
    @(negedge clk);
    chk("mid_fresh_load", 32'(outs), 32'(pk(1'b0, 3'd0, 3'd0, 4'd1, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0)));
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
